// File: rtl/shared_gate_arbiter.sv
// Arbitrates NREQ requesters onto one shared 2-input AND gate, holds operands for SETTLE cycles, returns the result.
// Optional build macro: SHARED_GATE_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module shared_gate_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in1_bus,
    input  logic [NREQ-1:0] in2_bus,
    output logic            gate_in1,
    output logic            gate_in2,
    input  logic            gate_out,
    output logic [NREQ-1:0] grant,
    output logic            done,
    output logic            result,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [NREQ-1:0]   grant_r;
    logic              gate_in1_r;
    logic              gate_in2_r;
    logic              result_r;
    logic              done_r;
    logic              busy_s;
    logic              win_valid_s;
    logic [PW-1:0]     win_idx_s;
    logic [PW-1:0]     lo_idx_s;
    logic [NREQ-1:0]   win_onehot_s;

    // Lowest set request index over the whole vector
    always_comb begin
        lo_idx_s = {PW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            lo_idx_s = req[i] ? PW'(i) : lo_idx_s;
        end
    end

`ifdef SHARED_GATE_FIXED_PRIO_EN

    // Fixed priority: lowest index always wins
    always_comb begin
        win_valid_s = |req;
        win_idx_s   = lo_idx_s;
    end

`else

    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   win_r;
    logic [NREQ-1:0] hi_s;
    logic [PW-1:0]   hi_idx_s;

    // Round-robin: first request at or above the pointer, else wrap to the lowest request
    always_comb begin
        hi_s     = {NREQ{1'b0}};
        hi_idx_s = {PW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            hi_s[i] = req[i] & (PW'(i) >= ptr_r);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            hi_idx_s = hi_s[i] ? PW'(i) : hi_idx_s;
        end
        win_valid_s = |req;
        if (|hi_s) begin
            win_idx_s = hi_idx_s;
        end else begin
            win_idx_s = lo_idx_s;
        end
    end

    // Winner memory and pointer advance once the transaction retires
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r <= {PW{1'b0}};
            win_r <= {PW{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && win_valid_s) begin
                win_r <= win_idx_s;
            end else begin
                win_r <= win_r;
            end
            if (state_r == ST_DONE) begin
                if (win_r == PW'(NREQ - 1)) begin
                    ptr_r <= {PW{1'b0}};
                end else begin
                    ptr_r <= win_r + PW'(1);
                end
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

`endif

    // One-hot form of the selected winner
    always_comb begin
        win_onehot_s            = {NREQ{1'b0}};
        win_onehot_s[win_idx_s] = 1'b1;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Grant, operand hold, settle counter and result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_r    <= {NREQ{1'b0}};
            gate_in1_r <= 1'b0;
            gate_in2_r <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            result_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        grant_r    <= win_onehot_s;
                        gate_in1_r <= in1_bus[win_idx_s];
                        gate_in2_r <= in2_bus[win_idx_s];
                        cnt_r      <= CNT_LOAD;
                    end else begin
                        grant_r    <= {NREQ{1'b0}};
                        gate_in1_r <= 1'b0;
                        gate_in2_r <= 1'b0;
                        cnt_r      <= {CW{1'b0}};
                    end
                    done_r <= 1'b0;
                end
                ST_HOLD: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= gate_out;
                        done_r   <= 1'b1;
                    end else begin
                        done_r   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    grant_r    <= {NREQ{1'b0}};
                    gate_in1_r <= 1'b0;
                    gate_in2_r <= 1'b0;
                    done_r     <= 1'b0;
                    cnt_r      <= {CW{1'b0}};
                end
                default: begin
                    grant_r    <= {NREQ{1'b0}};
                    gate_in1_r <= 1'b0;
                    gate_in2_r <= 1'b0;
                    done_r     <= 1'b0;
                    cnt_r      <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        busy_s = (state_r != ST_IDLE);
    end

    assign grant    = grant_r;
    assign gate_in1 = gate_in1_r;
    assign gate_in2 = gate_in2_r;
    assign result   = result_r;
    assign done     = done_r;
    assign busy     = busy_s;

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Scoreboard bench for shared_gate_arbiter (NREQ=4, SETTLE=2) with a delayed AND gate model.
module tb_shared_gate_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] in1_bus;
    logic [3:0] in2_bus;
    logic       gate_in1;
    logic       gate_in2;
    logic       gate_out;
    logic [3:0] grant;
    logic       done;
    logic       result;
    logic       busy;

    int         checks_total = 0;
    int         checks_pass  = 0;
    int         done_seen    = 0;
    int         cyc          = 0;
    logic [4:0] exp_q[$];
    int         done_cyc[$];

    shared_gate_arbiter #(.NREQ(4), .SETTLE(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .in1_bus  (in1_bus),
        .in2_bus  (in2_bus),
        .gate_in1 (gate_in1),
        .gate_in2 (gate_in2),
        .gate_out (gate_out),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .busy     (busy)
    );

    // Shared gate with a net delay shorter than the settle window
    assign #3 gate_out = gate_in1 & gate_in2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation {grant, result}
    always @(negedge clock) begin
        logic [4:0] e;
        if (done === 1'b1) begin
            done_seen++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_done: got grant %b result %b, expected no done", grant, result);
            end else begin
                e = exp_q.pop_front();
                check("done_grant", {28'd0, grant}, {28'd0, e[4:1]});
                check("done_result", {31'd0, result}, {31'd0, e[0]});
            end
        end
    end

    task automatic wait_dones(input int target);
        for (int k = 0; k < 60 && done_seen < target; k++) begin
            @(negedge clock); #1;
        end
        if (done_seen < target) begin
            checks_total++;
            $display("FAIL wait_done: got %0d dones, expected %0d", done_seen, target);
        end
    endtask

    task automatic step;
        @(negedge clock); #1;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        in1_bus = 4'b0000;
        in2_bus = 4'b0000;
        step();
        step();
        check("reset_state", {26'd0, grant, gate_in1, gate_in2, done, result, busy}, 32'd0);
        reset = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle", {26'd0, grant, gate_in1, gate_in2, done, result, busy}, 32'd0);
        end

        // Single request, operands 1/1
        req = 4'b0001; in1_bus = 4'b0001; in2_bus = 4'b0001;
        exp_q.push_back({4'b0001, 1'b1});
        step();
        check("single_grant", {28'd0, grant}, 32'h1);
        check("single_busy_gate", {29'd0, busy, gate_in1, gate_in2}, 32'h7);
        req = 4'b0000;
        wait_dones(1);
        step();
        check("single_release", {27'd0, grant, busy}, 32'd0);

        // Operand change during HOLD is ignored
        req = 4'b0001; in1_bus = 4'b0001; in2_bus = 4'b0001;
        exp_q.push_back({4'b0001, 1'b1});
        step();
        in2_bus = 4'b0000; req = 4'b0000;
        step();
        check("hold_gate_in2", {31'd0, gate_in2}, 32'h1);
        wait_dones(2);
        step();

        // Result zero from requester 1
        req = 4'b0010; in1_bus = 4'b0010; in2_bus = 4'b0000;
        exp_q.push_back({4'b0010, 1'b0});
        step();
        req = 4'b0000;
        wait_dones(3);
        step();

        // Fairness with all requesting, starting from a cleared pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        done_cyc.delete();
        in1_bus = 4'b1111; in2_bus = 4'b0101;
`ifdef SHARED_GATE_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) exp_q.push_back({4'b0001, 1'b1});
`else
        exp_q.push_back({4'b0001, 1'b1});
        exp_q.push_back({4'b0010, 1'b0});
        exp_q.push_back({4'b0100, 1'b1});
        exp_q.push_back({4'b1000, 1'b0});
        exp_q.push_back({4'b0001, 1'b1});
`endif
        req = 4'b1111;
        wait_dones(done_seen + 5);
        req = 4'b0000;
        step();
        check("rr_done_count", done_cyc.size(), 32'd5);
        for (int j = 0; j + 1 < done_cyc.size(); j++) begin
            check("rr_spacing", done_cyc[j+1] - done_cyc[j], 32'd4);
        end

        // Move pointer to 3, then contend with wrap-around
        in1_bus = 4'b1111; in2_bus = 4'b1111;
        req = 4'b0100;
        exp_q.push_back({4'b0100, 1'b1});
        step();
        req = 4'b0000;
        wait_dones(done_seen + 1);
        step();
`ifdef SHARED_GATE_FIXED_PRIO_EN
        exp_q.push_back({4'b0001, 1'b1});
        exp_q.push_back({4'b0001, 1'b1});
`else
        exp_q.push_back({4'b1000, 1'b1});
        exp_q.push_back({4'b0001, 1'b1});
`endif
        req = 4'b1001;
        wait_dones(done_seen + 2);
        req = 4'b0000;
        step();

        // Reset mid-transaction clears outputs at once and loses the transaction
        req = 4'b0010;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("async_reset", {24'd0, grant, gate_in1, gate_in2, done, busy}, 32'd0);
        step();
        reset = 1'b0;
        exp_q.push_back({4'b0010, 1'b1});
        step();
        check("post_reset_grant", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        wait_dones(done_seen + 1);
        step();
        step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
